// File: rtl/uart_tx_buffered.sv
// ============================================================================
//  Module   : uart_tx_buffered
//  Brief    : Buffered UART transmitter with a circular FIFO and a parametrised
//             frame engine (data width, stop bits, baud divider). The parity
//             bit is built only when UART_TX_PARITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          send,
    input  logic [DATA_BITS-1:0]          data,
    output logic                          ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          uart_tx
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [c_BW-1:0] c_BAUD_RELOAD = c_BW'(CLK_DIV - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE    = c_BW'(1);
    localparam logic [c_CW-1:0] c_DEPTH       = c_CW'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE     = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE     = c_AW'(1);
    localparam logic [3:0]      c_LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_LAST_STOP   = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic       c_PAR_ODD   = (PARITY_ODD != 0);
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // Elaboration-time guard against unsupported configurations.
    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        !(STOP_BITS == 1 || STOP_BITS == 2) || FIFO_DEPTH < 2 ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_bad_params
        $error("uart_tx_buffered: unsupported parameter combination");
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;

    logic [2:0]           r_state;
    logic [c_BW-1:0]      r_baud;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic                 w_push;
    logic                 w_pop;
    logic                 w_tick;
    logic                 w_has_data;
    logic                 w_frame_end;
    logic [DATA_BITS-1:0] w_head;
    logic [DATA_BITS-1:0] w_shift_next;

    assign w_push       = send && ready;
    assign w_tick       = (r_baud == '0);
    assign w_has_data   = (r_count != '0);
    assign w_frame_end  = (r_state == c_ST_STOP) && w_tick && (r_bit_cnt == c_LAST_STOP);
    assign w_pop        = w_has_data && ((r_state == c_ST_IDLE) || w_frame_end);
    assign w_head       = r_mem[r_rd_ptr];
    assign w_shift_next = r_shift >> 1;

    assign ready      = (r_count != c_DEPTH);
    assign busy       = (r_state != c_ST_IDLE) || w_has_data;
    assign fifo_count = r_count;
    assign uart_tx    = r_tx;

    // Storage needs no reset: cleared pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= (^w_head) ^ c_PAR_ODD;
`endif
                        r_baud    <= c_BAUD_RELOAD;
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_START;
                        r_tx      <= 1'b0;
                    end
                end
                c_ST_START: begin
                    if (w_tick) begin
                        r_baud    <= c_BAUD_RELOAD;
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        r_baud <= c_BAUD_RELOAD;
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= c_ST_PARITY;
                            r_tx      <= r_parity;
`else
                            r_state   <= c_ST_STOP;
                            r_tx      <= 1'b1;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_ST_PARITY: begin
                    if (w_tick) begin
                        r_baud    <= c_BAUD_RELOAD;
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_STOP;
                        r_tx      <= 1'b1;
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (w_tick) begin
                        r_baud <= c_BAUD_RELOAD;
                        if (r_bit_cnt == c_LAST_STOP) begin
                            r_bit_cnt <= '0;
                            // Chain straight into the next start bit when data is waiting.
                            if (w_has_data) begin
                                r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                                r_parity <= (^w_head) ^ c_PAR_ODD;
`endif
                                r_state  <= c_ST_START;
                                r_tx     <= 1'b0;
                            end else begin
                                r_state  <= c_ST_IDLE;
                                r_tx     <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud - c_BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
//  Module   : tb_uart_tx_buffered
//  Brief    : Self-checking bench for uart_tx_buffered; frame expectations are
//             queued on accepted sends and checked cycle by cycle on the line.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

`ifdef UART_TX_PARITY_EN
    localparam int c_P = 1;
`else
    localparam int c_P = 0;
`endif
    localparam int c_NB1 = 1 + 8 + c_P + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       send = 1'b0;
    logic [7:0] data = '0;
    logic       ready, busy, uart_tx;
    logic [2:0] fifo_count;

    logic       send2 = 1'b0;
    logic [6:0] data2 = '0;
    logic       ready2, busy2, tx2;
    logic [2:0] count2;

    logic       send3 = 1'b0;
    logic [7:0] data3 = '0;
    logic       ready3, busy3, tx3;
    logic [2:0] count3;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int frames_done = 0;

    logic [7:0] sb [$];

    always #5 clk = ~clk;

    uart_tx_buffered u_dut (
        .clk(clk), .rst(rst), .send(send), .data(data), .ready(ready),
        .busy(busy), .fifo_count(fifo_count), .uart_tx(uart_tx)
    );

    uart_tx_buffered #(.CLK_DIV(3), .DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .send(send2), .data(data2), .ready(ready2),
        .busy(busy2), .fifo_count(count2), .uart_tx(tx2)
    );

    uart_tx_buffered #(.PARITY_ODD(1)) u_dut3 (
        .clk(clk), .rst(rst), .send(send3), .data(data3), .ready(ready3),
        .busy(busy3), .fifo_count(count3), .uart_tx(tx3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line levels for one frame, LSB = start bit.
    function automatic logic [15:0] frame8(input logic [7:0] w, input logic odd);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = w;
`ifdef UART_TX_PARITY_EN
        f[9] = (^w) ^ odd;
`else
        f[15] = f[15] | odd;
`endif
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [7:0] w, input logic exp_accept);
        send = 1'b1;
        data = w;
        chk("ready_before_send", ready, exp_accept);
        if (exp_accept) sb.push_back(w);
        tick();
        send = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int i;
        i = 0;
        while (frames_done < target && i < budget) begin
            tick();
            i++;
        end
        chk("frames_drained", frames_done, target);
    endtask

    task automatic check_serial(input int sel, input logic [15:0] bits, input int nbits,
                                input int div, input string tag);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                tick();
                chk(tag, (sel == 2) ? tx2 : tx3, bits[b]);
            end
        end
    endtask

    // Line monitor for the default instance.
    bit          mon_active = 1'b0;
    bit          mon_expect_start = 1'b0;
    int          mon_cyc = 0;
    int          idle_wait = 0;
    logic [15:0] mon_bits = '1;

    always @(negedge clk) begin
        if (rst) begin
            mon_active       = 1'b0;
            mon_expect_start = 1'b0;
            idle_wait        = 0;
        end else begin
            if (!mon_active) begin
                if (mon_expect_start) begin
                    chk("b2b_start", uart_tx, 1'b0);
                    mon_expect_start = 1'b0;
                end
                if (uart_tx === 1'b0) begin
                    chk("start_has_word", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        mon_bits   = frame8(sb.pop_front(), 1'b0);
                        mon_active = 1'b1;
                        mon_cyc    = 0;
                        idle_wait  = 0;
                    end
                end else if (sb.size() != 0) begin
                    idle_wait++;
                    if (idle_wait > 3) begin
                        chk("start_latency", idle_wait, 3);
                        void'(sb.pop_front());
                        idle_wait = 0;
                    end
                end
            end
            if (mon_active) begin
                chk("frame_bit", uart_tx, mon_bits[mon_cyc / 4]);
                mon_cyc++;
                if (mon_cyc == c_NB1 * 4) begin
                    mon_active       = 1'b0;
                    frames_done++;
                    mon_expect_start = (sb.size() != 0);
                end
            end
        end
    end

    initial begin
        logic [15:0] f2;
        logic [15:0] f3;
        int target;

        repeat (3) tick();
        chk("rst_tx", uart_tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        rst = 1'b0;

        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_state", {uart_tx, ready, busy, fifo_count}, 6'b110000);
        end

        // Single 0xAA frame with exact latency and busy timing.
        send1(8'hAA, 1'b1);
        chk("aa_tx_after_accept", uart_tx, 1'b1);
        chk("aa_count_after_accept", fifo_count, 3'd1);
        chk("aa_busy_after_accept", busy, 1'b1);
        tick();
        chk("aa_start_edge", uart_tx, 1'b0);
        chk("aa_count_after_pop", fifo_count, 3'd0);
        repeat (c_NB1 * 4 - 1) tick();
        chk("aa_busy_last_stop", busy, 1'b1);
        tick();
        chk("aa_busy_after_frame", busy, 1'b0);
        chk("aa_tx_after_frame", uart_tx, 1'b1);
        chk("aa_frame_count", frames_done, 1);
        repeat (5) tick();

        // Five back-to-back words, then overflow attempt.
        target = frames_done + 5;
        send1(8'h01, 1'b1);
        send1(8'h02, 1'b1);
        send1(8'h03, 1'b1);
        send1(8'h04, 1'b1);
        send1(8'h05, 1'b1);
        chk("full_count", fifo_count, 3'd4);
        chk("full_ready", ready, 1'b0);
        send1(8'h06, 1'b0);
        chk("dropped_count", fifo_count, 3'd4);
        wait_frames(target, 5 * c_NB1 * 4 + 40);
        chk("b2b_busy_after", busy, 1'b0);
        chk("b2b_count_after", fifo_count, 3'd0);
        repeat (5) tick();

        // Parity pattern on the default (even) instance.
        target = frames_done + 1;
        send1(8'h07, 1'b1);
        wait_frames(target, c_NB1 * 4 + 20);
        repeat (5) tick();

        // Reset in the middle of data bit 3 with two words queued.
        send1(8'h31, 1'b1);
        send1(8'h32, 1'b1);
        send1(8'h33, 1'b1);
        chk("pre_rst_count", fifo_count, 3'd2);
        repeat (16) tick();
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        sb.delete();
        tick();
        chk("mid_rst_tx", uart_tx, 1'b1);
        chk("mid_rst_count", fifo_count, 3'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", ready, 1'b1);
        rst = 1'b0;
        target = frames_done;
        for (int i = 0; i < 60; i++) begin
            tick();
            chk("post_rst_quiet", {uart_tx, busy, fifo_count}, 5'b10000);
        end
        chk("post_rst_no_frames", frames_done, target);

        // 7 data bits, 2 stop bits, divider 3.
`ifdef UART_TX_PARITY_EN
        f2 = {5'b11111, 2'b11, 1'b0, 7'h55, 1'b0};
`else
        f2 = {6'b111111, 2'b11, 7'h55, 1'b0};
`endif
        send2 = 1'b1;
        data2 = 7'h55;
        chk("d2_ready", ready2, 1'b1);
        tick();
        send2 = 1'b0;
        chk("d2_tx_after_accept", tx2, 1'b1);
        chk("d2_busy_after_accept", busy2, 1'b1);
        check_serial(2, f2, 1 + 7 + c_P + 2, 3, "d2_frame_bit");
        tick();
        chk("d2_busy_after_frame", busy2, 1'b0);
        chk("d2_tx_after_frame", tx2, 1'b1);

        // Odd-parity instance with the same 0x07 pattern.
        f3 = frame8(8'h07, 1'b1);
        send3 = 1'b1;
        data3 = 8'h07;
        chk("d3_ready", ready3, 1'b1);
        tick();
        send3 = 1'b0;
        check_serial(3, f3, c_NB1, 4, "d3_frame_bit");
        tick();
        chk("d3_busy_after_frame", busy3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
